// File: rtl/usb_data_buffer.sv
// usb_data_buffer
//   Shared 64-byte FIFO between the USB RX/TX datapaths and the host side.
//   Writers: RX datapath (store_rx_packet_data/rx_packet_data) and host TX
//   load (store_tx_data/tx_data); RX wins when both strobe together.
//   Readers: host (get_rx_data) and TX datapath (get_tx_packet_data); both
//   strobes together count as a single read.  Read data appears one cycle
//   after an accepted read and is held until the next accepted read.
// Ports
//   clk, n_rst            clock, asynchronous active-low reset
//   store_rx_packet_data  RX write strobe,  rx_packet_data  RX write byte
//   store_tx_data         host write strobe, tx_data        host write byte
//   get_rx_data           host read strobe
//   get_tx_packet_data    TX read strobe
//   flush, clear          synchronous empty requests (highest priority)
//   rx_data/tx_packet_data read data register (same register, two views)
//   buffer_occupancy      bytes stored, 0..DEPTH
//   buffer_full/empty     combinational occupancy flags
//   overflow/underflow    registered one-cycle error pulses
module usb_data_buffer #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned OCC_W  = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             store_tx_data,
  input  logic [7:0]       tx_data,
  input  logic             get_rx_data,
  input  logic             get_tx_packet_data,
  input  logic             flush,
  input  logic             clear,
  output logic [7:0]       rx_data,
  output logic [7:0]       tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             buffer_full,
  output logic             buffer_empty,
  output logic             overflow,
  output logic             underflow
);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [7:0]        data_q, data_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              wr_req, rd_req, empty_req;
  logic              is_full, is_empty;
  logic              wr_acc, rd_acc;
  logic [7:0]        wr_byte;

  assign wr_req    = store_rx_packet_data | store_tx_data;
  assign rd_req    = get_rx_data | get_tx_packet_data;
  assign empty_req = flush | clear;
  assign wr_byte   = store_rx_packet_data ? rx_packet_data : tx_data;

  assign is_full  = (occ_q == OCC_W'(DEPTH));
  assign is_empty = (occ_q == '0);

  // A write at full is only accepted when a read frees the slot in the same
  // cycle; wr_ptr == rd_ptr then, and the read still sees the old byte.
  assign rd_acc = rd_req & ~is_empty & ~empty_req;
  assign wr_acc = wr_req & (~is_full | rd_acc) & ~empty_req;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    data_d   = data_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (empty_req) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        data_d   = mem_q[rd_ptr_q];
      end
      case ({wr_acc, rd_acc})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
      // Dual-strobe collision drops the TX byte even when the RX byte lands.
      ovf_d = (store_rx_packet_data & store_tx_data) | (wr_req & ~wr_acc);
      unf_d = rd_req & is_empty;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_byte;
  end

  assign rx_data          = data_q;
  assign tx_packet_data   = data_q;
  assign buffer_occupancy = occ_q;
  assign buffer_full      = is_full;
  assign buffer_empty     = is_empty;
  assign overflow         = ovf_q;
  assign underflow        = unf_q;

endmodule
